// File: rtl/key_scan_filter.sv
// key_scan_filter: N-channel key synchroniser and debouncer with
// registered press, release, long-press and auto-repeat pulses.
module key_scan_filter #(
  parameter int N_KEYS       = 4,
  parameter int ACTIVE_LOW   = 1,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int LONG_CYC     = 50000000,
  parameter int REPEAT_CYC   = 10000000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_in,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long,
  output logic [N_KEYS-1:0] key_repeat
);

  localparam int DW   = $clog2(DEBOUNCE_CYC);
  localparam int HMAX = (LONG_CYC > REPEAT_CYC) ? LONG_CYC : REPEAT_CYC;
  localparam int HW   = $clog2(HMAX + 1);
  localparam int RP_M = (REPEAT_CYC > 0) ? REPEAT_CYC - 1 : 0;

  localparam logic [DW-1:0] DB_TOP = DW'(DEBOUNCE_CYC - 1);
  localparam logic [HW-1:0] LG_TOP = HW'(LONG_CYC - 1);
  localparam logic [HW-1:0] RP_TOP = HW'(RP_M);
  localparam logic          RP_EN  = (REPEAT_CYC != 0);

  localparam logic [N_KEYS-1:0] POL = {N_KEYS{ACTIVE_LOW != 0}};

  typedef enum logic [1:0] {
    IDLE,
    PRESS_FILT,
    DOWN,
    REL_FILT
  } state_t;

  logic [N_KEYS-1:0] sync1, sync2, p;

  state_t        st_q [N_KEYS];
  state_t        st_d [N_KEYS];
  logic [DW-1:0] db_q [N_KEYS];
  logic [DW-1:0] db_d [N_KEYS];
  logic [HW-1:0] hc_q [N_KEYS];
  logic [HW-1:0] hc_d [N_KEYS];

  logic [N_KEYS-1:0] ld_q, ld_d;
  logic [N_KEYS-1:0] lvl_d, press_d, rel_d;
  logic [N_KEYS-1:0] long_d, rep_d;

  assign p = sync2 ^ POL;

  // two-flop synchroniser, cleared to the released pin level
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= POL;
      sync2 <= POL;
    end else begin
      sync1 <= key_in;
      sync2 <= sync1;
    end
  end

  // per-channel state, counters and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < N_KEYS; i++) begin
        st_q[i] <= IDLE;
        db_q[i] <= '0;
        hc_q[i] <= '0;
      end
      ld_q        <= '0;
      key_state   <= '0;
      key_press   <= '0;
      key_release <= '0;
      key_long    <= '0;
      key_repeat  <= '0;
    end else begin
      for (int i = 0; i < N_KEYS; i++) begin
        st_q[i] <= st_d[i];
        db_q[i] <= db_d[i];
        hc_q[i] <= hc_d[i];
      end
      ld_q        <= ld_d;
      key_state   <= lvl_d;
      key_press   <= press_d;
      key_release <= rel_d;
      key_long    <= long_d;
      key_repeat  <= rep_d;
    end
  end

  // next-state: debounce both edges, schedule hold events while down
  always_comb begin
    ld_d    = ld_q;
    lvl_d   = key_state;
    press_d = '0;
    rel_d   = '0;
    long_d  = '0;
    rep_d   = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      st_d[i] = st_q[i];
      db_d[i] = db_q[i];
      hc_d[i] = hc_q[i];
      unique case (st_q[i])
        IDLE: begin
          if (p[i]) begin
            st_d[i] = PRESS_FILT;
            db_d[i] = '0;
          end
        end
        PRESS_FILT: begin
          if (!p[i]) begin
            st_d[i] = IDLE;
          end else if (db_q[i] == DB_TOP) begin
            st_d[i]    = DOWN;
            press_d[i] = 1'b1;
            lvl_d[i]   = 1'b1;
            hc_d[i]    = '0;
            ld_d[i]    = 1'b0;
          end else begin
            db_d[i] = db_q[i] + DW'(1);
          end
        end
        DOWN: begin
          if (!ld_q[i] && hc_q[i] == LG_TOP) begin
            long_d[i] = 1'b1;
            ld_d[i]   = 1'b1;
            hc_d[i]   = '0;
          end else if (ld_q[i] && RP_EN && hc_q[i] == RP_TOP) begin
            rep_d[i] = 1'b1;
            hc_d[i]  = '0;
          end else if (hc_q[i] != '1) begin
            hc_d[i] = hc_q[i] + HW'(1);
          end
          if (!p[i]) begin
            st_d[i] = REL_FILT;
            db_d[i] = '0;
          end
        end
        REL_FILT: begin
          if (p[i]) begin
            st_d[i] = DOWN;
          end else if (db_q[i] == DB_TOP) begin
            st_d[i]  = IDLE;
            rel_d[i] = 1'b1;
            lvl_d[i] = 1'b0;
          end else begin
            db_d[i] = db_q[i] + DW'(1);
          end
        end
      endcase
    end
  end

endmodule
